// File: rtl/match_event_counter.sv
// Counts accepted key entries and detector matches in saturating 2-digit BCD
// counters and scans both counts onto a 4-digit active-low 7-segment display.
module match_event_counter #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_p,
  input  logic       result,
  input  logic       clr,
  output logic [7:0] entry_bcd,
  output logic [7:0] match_bcd,
  output logic       sat,
  output logic [3:0] sel,
  output logic [7:0] data
);

  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [7:0]       r_entry;
  logic [7:0]       r_match;
  logic             r_sat;
  logic             r_result_d;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [3:0]       r_sel;
  logic [7:0]       r_data;

  logic             w_match_ev;
  logic [3:0]       w_digit;
  logic             w_dp;
  logic [3:0]       w_sel;
  logic [7:0]       w_data;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] n;
    n = v;
    if (v[3:0] == 4'd9) begin
      n[3:0] = 4'd0;
      n[7:4] = v[7:4] + 4'd1;
    end else begin
      n[3:0] = v[3:0] + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign w_match_ev = result & ~r_result_d;

  // Both counters are evaluated independently so simultaneous events each land.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry    <= 8'h00;
      r_match    <= 8'h00;
      r_sat      <= 1'b0;
      r_result_d <= 1'b0;
    end else if (clr) begin
      r_entry    <= 8'h00;
      r_match    <= 8'h00;
      r_sat      <= 1'b0;
      r_result_d <= result;
    end else begin
      r_result_d <= result;
      if (pulse_p) begin
        if (r_entry == 8'h99) r_sat   <= 1'b1;
        else                  r_entry <= bcd_inc(r_entry);
      end
      if (w_match_ev) begin
        if (r_match == 8'h99) r_sat   <= 1'b1;
        else                  r_match <= bcd_inc(r_match);
      end
    end
  end

  // Scan timing is independent of clr so the display keeps refreshing evenly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // NOTE: defaults assigned first so no path through the case infers a latch.
  always_comb begin
    w_digit = r_match[3:0];
    w_dp    = 1'b0;
    case (r_idx)
      2'd0: w_digit = r_match[3:0];
      2'd1: w_digit = r_match[7:4];
      2'd2: begin
        w_digit = r_entry[3:0];
        w_dp    = 1'b1;
      end
      default: w_digit = r_entry[7:4];
    endcase
    w_sel  = ~(4'b0001 << r_idx);
    w_data = seg7(w_digit);
    if (w_dp) w_data[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= 4'b1110;
      r_data <= 8'hC0;
    end else begin
      r_sel  <= w_sel;
      r_data <= w_data;
    end
  end

  assign entry_bcd = r_entry;
  assign match_bcd = r_match;
  assign sat       = r_sat;
  assign sel       = r_sel;
  assign data      = r_data;

endmodule

// File: tb/tb_match_event_counter.sv
// Self-checking bench for match_event_counter: directed scenarios plus random
// stimulus compared against an integer-count reference model.
module tb_match_event_counter;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_p = 1'b0;
  logic       result = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] entry_bcd;
  logic [7:0] match_bcd;
  logic       sat;
  logic [3:0] sel;
  logic [7:0] data;

  int errors = 0;
  int checks = 0;

  match_event_counter #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_p   (pulse_p),
    .result    (result),
    .clr       (clr),
    .entry_bcd (entry_bcd),
    .match_bcd (match_bcd),
    .sat       (sat),
    .sel       (sel),
    .data      (data)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer counts, a cycle counter for the scan
  // position, and the display value latched from the pre-edge state.
  int         m_ent, m_mat, m_cyc;
  logic       m_sat, m_prev;
  logic [3:0] m_sel;
  logic [7:0] m_data;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    int idx;
    int dig;
    logic [7:0] s;
    if (rst) begin
      m_ent = 0; m_mat = 0; m_cyc = 0;
      m_sat = 1'b0; m_prev = 1'b0;
      m_sel = 4'b1110; m_data = 8'hC0;
    end else begin
      idx = (m_cyc / SD) % 4;
      case (idx)
        0:       dig = m_mat % 10;
        1:       dig = m_mat / 10;
        2:       dig = m_ent % 10;
        default: dig = m_ent / 10;
      endcase
      s = seg_of(dig);
      if (idx == 2) s[7] = 1'b0;
      m_sel  = 4'b1111 ^ (4'b0001 << idx);
      m_data = s;
      if (clr) begin
        m_ent = 0; m_mat = 0; m_sat = 1'b0;
      end else begin
        if (pulse_p) begin
          if (m_ent == 99) m_sat = 1'b1; else m_ent++;
        end
        if (result && !m_prev) begin
          if (m_mat == 99) m_sat = 1'b1; else m_mat++;
        end
      end
      m_prev = result;
      m_cyc++;
    end
  end

  // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
  task automatic drive(input logic p, input logic r, input logic c);
    pulse_p = p;
    result  = r;
    clr     = c;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h00) begin errors++; $display("FAIL reset_entry: got %h want 00", entry_bcd); end
    checks++; if (match_bcd !== 8'h00) begin errors++; $display("FAIL reset_match: got %h want 00", match_bcd); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat); end
    checks++; if (sel !== 4'b1110) begin errors++; $display("FAIL reset_sel: got %b want 1110", sel); end
    checks++; if (data !== 8'hC0) begin errors++; $display("FAIL reset_data: got %h want C0", data); end
  endtask

  task automatic test_result_at_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    checks++; if (match_bcd !== 8'h01) begin errors++; $display("FAIL result_at_reset: got %h want 01", match_bcd); end
    checks++; if (entry_bcd !== 8'h00) begin errors++; $display("FAIL result_at_reset_entry: got %h want 00", entry_bcd); end
  endtask

  task automatic test_basic();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h01) begin errors++; $display("FAIL basic_latency: got %h want 01", entry_bcd); end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h03) begin errors++; $display("FAIL basic_entry: got %h want 03", entry_bcd); end
    checks++; if (match_bcd !== 8'h01) begin errors++; $display("FAIL basic_match: got %h want 01", match_bcd); end
  endtask

  task automatic test_back_to_back_rollover();
    drive(1'b0, 1'b0, 1'b1);
    repeat (9) drive(1'b1, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h09) begin errors++; $display("FAIL roll_09: got %h want 09", entry_bcd); end
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h10) begin errors++; $display("FAIL roll_10: got %h want 10", entry_bcd); end
    repeat (89) drive(1'b1, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h99) begin errors++; $display("FAIL roll_99: got %h want 99", entry_bcd); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL roll_sat_early: got %b want 0", sat); end
    drive(1'b1, 1'b0, 1'b0);
    checks++; if (entry_bcd !== 8'h99) begin errors++; $display("FAIL sat_hold: got %h want 99", entry_bcd); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_set: got %b want 1", sat); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", sat); end
  endtask

  task automatic test_simultaneous_clear();
    drive(1'b0, 1'b0, 1'b1);
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL clr_sat: got %b want 0", sat); end
    drive(1'b1, 1'b1, 1'b0);
    checks++; if ({entry_bcd, match_bcd} !== 16'h0101) begin errors++; $display("FAIL simul: got %h want 0101", {entry_bcd, match_bcd}); end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    checks++; if ({entry_bcd, match_bcd} !== 16'h0000) begin errors++; $display("FAIL clr_prio: got %h want 0000", {entry_bcd, match_bcd}); end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    checks++; if (match_bcd !== 8'h00) begin errors++; $display("FAIL clr_release: got %h want 00", match_bcd); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel  [4];
    logic [7:0] exp_data [4];
    logic [3:0] prev;
    int         k;
    exp_sel  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_data = '{8'hF9, 8'hF8, 8'h19, 8'hA4};
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    // 24 entries, and a rising result edge on every odd cycle up to 141 gives 71 matches
    for (int i = 0; i < 142; i++) drive(i < 24, i[0], 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++; if ({entry_bcd, match_bcd} !== 16'h2471) begin errors++; $display("FAIL scan_counts: got %h want 2471", {entry_bcd, match_bcd}); end
    prev = sel;
    drive(1'b0, 1'b0, 1'b0);
    k = 0;
    while (!(sel == 4'b1110 && prev != 4'b1110) && k < 4 * SD + 2) begin
      prev = sel;
      drive(1'b0, 1'b0, 1'b0);
      k++;
    end
    checks++;
    if (k >= 4 * SD + 2) begin
      errors++; $display("FAIL scan_align: digit 0 never reselected, sel=%b", sel);
    end else begin
      for (int j = 0; j < 4 * SD; j++) begin
        checks++;
        if (sel !== exp_sel[j / SD] || data !== exp_data[j / SD]) begin
          errors++; $display("FAIL scan_seq[%0d]: got %b/%h want %b/%h", j, sel, data, exp_sel[j / SD], exp_data[j / SD]);
        end
        checks++;
        if (sel !== m_sel || data !== m_data) begin
          errors++; $display("FAIL scan_model[%0d]: got %b/%h model %b/%h", j, sel, data, m_sel, m_data);
        end
        drive(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) drive(i < 25, (i < 26) && i[0], 1'b0);
    checks++; if ({entry_bcd, match_bcd} !== 16'h2513) begin errors++; $display("FAIL mid_counts: got %h want 2513", {entry_bcd, match_bcd}); end
    k = 0;
    while (((m_cyc / SD) % 4) != 2 && k < 4 * SD) begin
      drive(1'b0, 1'b0, 1'b0);
      k++;
    end
    checks++;
    if (k >= 4 * SD) begin errors++; $display("FAIL mid_idx: scan index 2 not reached"); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++; if ({entry_bcd, match_bcd} !== 16'h0000) begin errors++; $display("FAIL mid_rst_counts: got %h want 0000", {entry_bcd, match_bcd}); end
    checks++; if (sel !== 4'b1110 || data !== 8'hC0) begin errors++; $display("FAIL mid_rst_disp: got %b/%h want 1110/C0", sel, data); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL mid_rst_sat: got %b want 0", sat); end
    repeat (SD) begin
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (sel !== 4'b1110) begin errors++; $display("FAIL mid_restart_hold: got %b want 1110", sel); end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (sel !== 4'b1101) begin errors++; $display("FAIL mid_restart_adv: got %b want 1101", sel); end
  endtask

  task automatic test_random();
    logic r;
    r = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 550; i++) begin
      logic p, c;
      if ($urandom_range(2, 0) == 0) r = ~r;
      if (i < 300) begin
        p   = 1'($urandom_range(1, 0));
        c   = ($urandom_range(39, 0) == 0);
        rst = ($urandom_range(99, 0) == 0);
      end else begin
        p   = ($urandom_range(3, 0) != 0);
        c   = 1'b0;
        rst = 1'b0;
      end
      drive(p, r, c);
      rst = 1'b0;
      checks++; if (entry_bcd !== to_bcd(m_ent)) begin errors++; $display("FAIL rand_entry[%0d]: got %h model %h", i, entry_bcd, to_bcd(m_ent)); end
      checks++; if (match_bcd !== to_bcd(m_mat)) begin errors++; $display("FAIL rand_match[%0d]: got %h model %h", i, match_bcd, to_bcd(m_mat)); end
      checks++; if (sat !== m_sat) begin errors++; $display("FAIL rand_sat[%0d]: got %b model %b", i, sat, m_sat); end
      checks++; if (sel !== m_sel) begin errors++; $display("FAIL rand_sel[%0d]: got %b model %b", i, sel, m_sel); end
      checks++; if (data !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h model %h", i, data, m_data); end
    end
    checks++; if (m_sat !== 1'b1 || sat !== 1'b1) begin errors++; $display("FAIL rand_saturated: got %b model %b want 1", sat, m_sat); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_result_at_reset();
    test_basic();
    test_back_to_back_rollover();
    test_simultaneous_clear();
    test_scan();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
